// File: rtl/dequant_pkg.sv
// dequant_pkg: shared types for the dequantizer scheduler.
//   dq_src_e    - request source (activation / weight)
//   dq_flags_t  - dequantizer exception flags {ovfl, unfl, excp}
//   dq_result_t - one buffered result: fp value, source, flags
package dequant_pkg;

    typedef enum logic {
        SRC_ACT    = 1'b0,
        SRC_WEIGHT = 1'b1
    } dq_src_e;

    typedef struct packed {
        logic ovfl;
        logic unfl;
        logic excp;
    } dq_flags_t;

    typedef struct packed {
        logic [31:0] fp;
        dq_src_e     src;
        dq_flags_t   flags;
    } dq_result_t;

    localparam int DQ_LATENCY_DEF = 5;

endpackage

// File: rtl/dq_result_fifo.sv
// dq_result_fifo: circular result buffer for the dequant scheduler.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   push, wdata    - write one result (never while full without a pop)
//   pop            - remove head entry (ignored when empty)
//   rdata          - head entry, zero when empty
//   empty, count   - occupancy status
module dq_result_fifo
    import dequant_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  dq_result_t               wdata,
    input  logic                     pop,
    output dq_result_t               rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    dq_result_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             full;

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign do_pop = pop & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset; mask it so the head reads zero when empty.
    assign rdata = empty ? '0 : mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/dequant_scheduler.sv
// dequant_scheduler: shares one pipelined dequantizer between a weight and an
// activation requester with round-robin arbitration, tracks in-flight items in
// a shadow valid/source pipe and lands results in a credit-protected FIFO.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   w_valid/w_ready/w_level       - weight request handshake and level
//   a_valid/a_ready/a_level       - activation request handshake and level
//   dq_level_int, dq_is_weight    - registered issue to the dequantizer
//   dq_fp, dq_ovfl/unfl/excp      - dequantizer result, DQ_LATENCY edges later
//   res_valid/res_ready           - result FIFO head handshake
//   res_data/res_is_weight/res_flags - head entry contents
//   exc_count                     - saturating count of flagged results
//   busy                          - anything in flight or buffered
module dequant_scheduler
    import dequant_pkg::*;
#(
    parameter int DQ_LATENCY = DQ_LATENCY_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [31:0]      w_level,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_level,
    output logic [31:0]      dq_level_int,
    output logic             dq_is_weight,
    input  logic [31:0]      dq_fp,
    input  logic             dq_ovfl,
    input  logic             dq_unfl,
    input  logic             dq_excp,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_is_weight,
    output logic [2:0]       res_flags,
    output logic [CNT_W-1:0] exc_count,
    output logic             busy
);

    localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W  = $clog2(DQ_LATENCY + 2);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + DQ_LATENCY + 2);

    dq_src_e             rr_ptr;
    // Bit 0 is the issue register; bit DQ_LATENCY lines up with dq_fp.
    logic [DQ_LATENCY:0] vld_pipe;
    logic [DQ_LATENCY:0] src_pipe;
    logic [INF_W-1:0]    inflight;
    logic [CNT_FW-1:0]   fifo_count;
    logic [OCC_W-1:0]    occupancy;
    logic                can_issue;
    logic                w_acc;
    logic                a_acc;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    dq_result_t          push_data;
    dq_result_t          head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= DQ_LATENCY; i++) inflight = inflight + INF_W'(vld_pipe[i]);
    end

    // Every accepted item owns a FIFO slot from acceptance until it is popped,
    // so the dequantizer (which cannot stall) never has its output dropped.
    assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_count);
    assign can_issue = ~rst & (occupancy < OCC_W'(FIFO_DEPTH));

    // Ready looks only at the competitor's valid, never the requester's own.
    assign w_ready = can_issue & ((rr_ptr == SRC_WEIGHT) | ~a_valid);
    assign a_ready = can_issue & ((rr_ptr == SRC_ACT)    | ~w_valid);
    assign w_acc   = w_valid & w_ready;
    assign a_acc   = a_valid & a_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= SRC_WEIGHT;
            vld_pipe     <= '0;
            src_pipe     <= '0;
            dq_level_int <= '0;
        end else begin
            if (w_acc)      rr_ptr <= SRC_ACT;
            else if (a_acc) rr_ptr <= SRC_WEIGHT;
            vld_pipe     <= {vld_pipe[DQ_LATENCY-1:0], w_acc | a_acc};
            src_pipe     <= {src_pipe[DQ_LATENCY-1:0], w_acc};
            dq_level_int <= w_acc ? w_level : (a_acc ? a_level : '0);
        end
    end

    assign dq_is_weight = src_pipe[0];

    assign push = vld_pipe[DQ_LATENCY];
    always_comb begin
        push_data       = '0;
        push_data.fp    = dq_fp;
        push_data.src   = src_pipe[DQ_LATENCY] ? SRC_WEIGHT : SRC_ACT;
        push_data.flags = '{ovfl: dq_ovfl, unfl: dq_unfl, excp: dq_excp};
    end

    assign pop = res_valid & res_ready;

    dq_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign res_valid     = ~fifo_empty;
    assign res_data      = head.fp;
    assign res_is_weight = (head.src == SRC_WEIGHT);
    assign res_flags     = head.flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_count <= '0;
        end else if (push && (|push_data.flags) && (exc_count != '1)) begin
            exc_count <= exc_count + 1'b1;
        end
    end

    assign busy = (inflight != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_dequant_scheduler.sv
module tb_dequant_scheduler;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int RES_LAT_STEPS = LAT + 2; // step index offset from accept to first visible result

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        w_valid = 1'b0, a_valid = 1'b0, res_ready = 1'b0;
    logic [31:0] w_level = '0, a_level = '0;
    logic        w_ready, a_ready, dq_is_weight, res_valid, res_is_weight, busy;
    logic [31:0] dq_level_int, res_data;
    logic [2:0]  res_flags;
    logic [15:0] exc_count;
    logic        w_ready2, a_ready2, dq_is_weight2, res_valid2, res_is_weight2, busy2;
    logic [31:0] dq_level_int2, res_data2;
    logic [2:0]  res_flags2;
    logic [1:0]  exc_count2;
    logic [31:0] dq_fp;
    logic        dq_ovfl, dq_unfl, dq_excp;

    // Stand-in for the dequantizer: known levels give the reference encodings,
    // anything else a deterministic scramble; flags derive from the level.
    function automatic logic [31:0] stub_fp(input logic [31:0] lv, input logic w);
        if (w) begin
            case (lv)
                32'd4096:     return 32'h40bfffe0;
                32'd14562:    return 32'h41aaa5e4;
                32'd0:        return 32'h00000000;
                32'hffffffff: return 32'hbabfffe0;
                32'hffffc000: return 32'hc1bfffe0;
                default: ;
            endcase
        end else if (lv == 32'd4096) return 32'h3c200013;
        return {lv[7:0] ^ 8'h5a, lv[31:9], w};
    endfunction

    function automatic logic [2:0] stub_fl(input logic [31:0] lv);
        logic signed [31:0] s;
        s = lv;
        return {s < -32'sd1000000000, lv == 32'd7, s > 32'sd1000000000};
    endfunction

    logic [31:0] sp_fp [LAT];
    logic [2:0]  sp_fl [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin sp_fp[i] <= '0; sp_fl[i] <= '0; end
        end else begin
            sp_fp[0] <= stub_fp(dq_level_int, dq_is_weight);
            sp_fl[0] <= stub_fl(dq_level_int);
            for (int i = 1; i < LAT; i++) begin sp_fp[i] <= sp_fp[i-1]; sp_fl[i] <= sp_fl[i-1]; end
        end
    end
    assign dq_fp = sp_fp[LAT-1];
    assign {dq_ovfl, dq_unfl, dq_excp} = sp_fl[LAT-1];

    dequant_scheduler #(.DQ_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_level(w_level),
        .a_valid(a_valid), .a_ready(a_ready), .a_level(a_level),
        .dq_level_int(dq_level_int), .dq_is_weight(dq_is_weight), .dq_fp(dq_fp),
        .dq_ovfl(dq_ovfl), .dq_unfl(dq_unfl), .dq_excp(dq_excp),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_is_weight(res_is_weight), .res_flags(res_flags), .exc_count(exc_count), .busy(busy));

    // Same traffic, narrow counter: exercises saturation. Its dq outputs equal
    // the main instance's, so it can share the stub.
    dequant_scheduler #(.DQ_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready2), .w_level(w_level),
        .a_valid(a_valid), .a_ready(a_ready2), .a_level(a_level),
        .dq_level_int(dq_level_int2), .dq_is_weight(dq_is_weight2), .dq_fp(dq_fp),
        .dq_ovfl(dq_ovfl), .dq_unfl(dq_unfl), .dq_excp(dq_excp),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .res_is_weight(res_is_weight2), .res_flags(res_flags2), .exc_count(exc_count2), .busy(busy2));

    // Reference model: items accepted but not yet popped, in acceptance order.
    typedef struct packed {
        logic [31:0] fp;
        logic        w;
        logic [2:0]  fl;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    int   outstanding = 0;
    bit   rr_w = 1'b1;
    int   exc_exp = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic step(input bit wv, input logic [31:0] wl, input bit av, input logic [31:0] al,
                        input bit rr, output bit wacc, output bit aacc, output bit rv,
                        output logic [31:0] pdata);
        bit   can, ew, ea;
        exp_t e;
        @(negedge clk);
        w_valid = wv; w_level = wl; a_valid = av; a_level = al; res_ready = rr;
        #1;
        can = (outstanding < DEPTH);
        ew  = can && (rr_w || !av);
        ea  = can && (!rr_w || !wv);
        checks++;
        if (w_ready !== ew || a_ready !== ea) begin
            errors++;
            $display("FAIL ready cyc=%0d w_ready=%b a_ready=%b expected %b %b", cyc, w_ready, a_ready, ew, ea);
        end
        wacc  = wv && ew;
        aacc  = av && ea;
        rv    = (res_valid === 1'b1);
        pdata = res_data;
        checks++;
        if (rv) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_result cyc=%0d data=%h expected none", cyc, res_data);
            end else begin
                if (res_data !== exp_q[0].fp || res_is_weight !== exp_q[0].w || res_flags !== exp_q[0].fl
                    || cyc - exp_q[0].acc < RES_LAT_STEPS) begin
                    errors++;
                    $display("FAIL result cyc=%0d got %h/%b/%b expected %h/%b/%b accepted cyc %0d",
                             cyc, res_data, res_is_weight, res_flags, exp_q[0].fp, exp_q[0].w, exp_q[0].fl, exp_q[0].acc);
                end
                if (rr) begin
                    exp_q.delete(0);
                    outstanding--;
                end
            end
        end else if (exp_q.size() != 0 && cyc - exp_q[0].acc >= RES_LAT_STEPS) begin
            errors++;
            $display("FAIL late_result cyc=%0d res_valid=0 expected %h (accepted cyc %0d)", cyc, exp_q[0].fp, exp_q[0].acc);
        end
        if (wacc || aacc) begin
            e.w   = wacc;
            e.fp  = stub_fp(wacc ? wl : al, wacc);
            e.fl  = stub_fl(wacc ? wl : al);
            e.acc = cyc;
            exp_q.push_back(e);
            outstanding++;
            rr_w = !wacc;
            if (e.fl != 3'b000) exc_exp++;
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic drain(input string name);
        bit wa, aa, rv;
        logic [31:0] pd;
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step(0, 0, 0, 0, 1, wa, aa, rv, pd);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout left=%0d expected 0", name, exp_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b expected 0", name, busy); end
        checks++;
        if (exc_count !== 16'(sat(exc_exp, 65535)) || exc_count2 !== 2'(sat(exc_exp, 3))) begin
            errors++;
            $display("FAIL %s_exc_count got %0d/%0d expected %0d/%0d", name, exc_count, exc_count2,
                     sat(exc_exp, 65535), sat(exc_exp, 3));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; w_valid = 1'b1; a_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, busy, w_ready, a_ready, dq_is_weight} !== 5'b0 || res_data !== 32'h0 ||
            dq_level_int !== 32'h0 || res_flags !== 3'b0 || res_is_weight !== 1'b0 || exc_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b busy=%b wr=%b ar=%b data=%h dq=%h exc=%0d expected all 0",
                     res_valid, busy, w_ready, a_ready, res_data, dq_level_int, exc_count);
        end
        rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
    endtask

    task automatic test_single();
        bit wa, aa, rv;
        logic [31:0] pd, first_data = '0;
        int first = 0;
        step(1, 32'd4096, 0, 0, 1, wa, aa, rv, pd);
        checks++;
        if (wa !== 1'b1) begin errors++; $display("FAIL single_accept got %b expected 1", wa); end
        for (int j = 1; j <= 12; j++) begin
            step(0, 0, 0, 0, 1, wa, aa, rv, pd);
            if (rv && first == 0) begin first = j; first_data = pd; end
        end
        checks++;
        if (first != RES_LAT_STEPS || first_data !== 32'h40bfffe0) begin
            errors++;
            $display("FAIL single_latency got step %0d data %h expected step %0d data 40bfffe0", first, first_data, RES_LAT_STEPS);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        bit wa, aa, rv, prev_w, want_w;
        logic [31:0] pd;
        int pops = 0;
        want_w = rr_w;
        for (int i = 0; i < 24; i++) begin
            step(1, 32'd14562, 1, 32'd4096, 1, wa, aa, rv, pd);
            if (rv) pops++;
            checks++;
            if ((wa ^ aa) !== 1'b1 || (i == 0 && wa !== want_w) || (i != 0 && wa === prev_w)) begin
                errors++;
                $display("FAIL b2b_grant i=%0d w=%b a=%b expected alternating single grant", i, wa, aa);
            end
            prev_w = wa;
        end
        checks++;
        if (pops != 24 - RES_LAT_STEPS) begin
            errors++;
            $display("FAIL b2b_throughput got %0d pops expected %0d", pops, 24 - RES_LAT_STEPS);
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        bit wa, aa, rv;
        logic [31:0] pd;
        int nacc = 0;
        for (int i = 0; i < 14; i++) begin
            step(1, 32'($urandom_range(0, 50000)), 0, 0, 0, wa, aa, rv, pd);
            nacc += int'(wa);
        end
        checks++;
        if (nacc != DEPTH || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit got %0d accepted w_ready=%b expected %0d and 0", nacc, w_ready, DEPTH);
        end
        drain("bp");
        step(1, 32'd123, 0, 0, 1, wa, aa, rv, pd);
        checks++;
        if (wa !== 1'b1) begin errors++; $display("FAIL bp_resume got %b expected 1", wa); end
        drain("bp_resume");
    endtask

    task automatic test_boundary();
        bit wa, aa, rv;
        logic [31:0] pd;
        logic [31:0] lv [3];
        logic [31:0] ex [3];
        logic [31:0] got [$];
        lv[0] = 32'd0;        ex[0] = 32'h00000000;
        lv[1] = 32'hffffffff; ex[1] = 32'hbabfffe0;
        lv[2] = 32'hffffc000; ex[2] = 32'hc1bfffe0;
        for (int i = 0; i < 3; i++) begin
            step(1, lv[i], 0, 0, 1, wa, aa, rv, pd);
            if (rv) got.push_back(pd);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 1, wa, aa, rv, pd);
            if (rv) got.push_back(pd);
        end
        checks++;
        if (got.size() != 3 || got[0] !== ex[0] || got[1] !== ex[1] || got[2] !== ex[2]) begin
            errors++;
            $display("FAIL boundary got %0d results expected 3 (00000000 babfffe0 c1bfffe0)", got.size());
        end
        drain("boundary");
    endtask

    task automatic test_random();
        bit wa, aa, rv;
        logic [31:0] pd;
        for (int i = 0; i < 300; i++)
            step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 3) != 0), wa, aa, rv, pd);
        drain("random");
    endtask

    task automatic test_reset_mid();
        bit wa, aa, rv;
        logic [31:0] pd;
        int seen = 0;
        for (int i = 0; i < 5; i++) step(1, 32'(1000 + i), 0, 0, 0, wa, aa, rv, pd);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, wa, aa, rv, pd);
        @(negedge clk);
        w_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state valid=%b busy=%b expected 1 1", res_valid, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%b busy=%b expected 0 0", res_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        outstanding = 0;
        rr_w = 1'b1;
        exc_exp = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 1, wa, aa, rv, pd);
            if (rv) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_discard got %0d results expected 0", seen); end
        drain("reset_mid");
    endtask

    task automatic test_exc();
        bit wa, aa, rv;
        logic [31:0] pd;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++)
                step(1, (i < 3) ? 32'h7000_0000 : 32'd100, 0, 0, 1, wa, aa, rv, pd);
            drain("exc");
            checks++;
            if (exc_count !== 16'(3 * (r + 1)) || exc_count2 !== 2'd3) begin
                errors++;
                $display("FAIL exc_sat round %0d got %0d/%0d expected %0d/3", r, exc_count, exc_count2, 3 * (r + 1));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_random();
        test_reset_mid();
        test_exc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
